// File: rtl/scan_pkg.sv
// Shared constants, counter-state type and width helper for the scan register bank.
package scan_pkg;

    localparam int MISR_W = 16;
    localparam logic [MISR_W-1:0] MISR_POLY = 16'h100B;

    typedef enum logic [1:0] {
        SC_IDLE,
        SC_SHIFT,
        SC_FULL
    } scnt_state_e;

    function automatic int calc_cw(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/scan_misr.sv
// 16-bit multiple-input signature register compacting per-chain scan-out bits.
module scan_misr
    import scan_pkg::*;
#(
    parameter int CHAINS = 4
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              EN,
    input  logic [CHAINS-1:0] DIN,
    output logic [MISR_W-1:0] SIG
);

    logic [MISR_W-1:0] r_sig;
    logic [MISR_W-1:0] w_din_ext;

    assign w_din_ext = MISR_W'(DIN);

    always_ff @(posedge CK) begin
        if (RST) begin
            r_sig <= '0;
        end else if (EN) begin
            r_sig <= {r_sig[MISR_W-2:0], 1'b0}
                     ^ (r_sig[MISR_W-1] ? MISR_POLY : '0)
                     ^ w_din_ext;
        end
    end

    assign SIG = r_sig;

endmodule

// File: rtl/scan_reg_bank.sv
// Multi-chain scan register bank with saturating shift counter.
// Define SCAN_MISR_EN to add the on-bank MISR and the SIG output.
module scan_reg_bank
    import scan_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter int               CHAINS  = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int              LEN     = WIDTH / CHAINS,
    localparam int              CW      = calc_cw(LEN)
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              E,
    input  logic              SE,
    input  logic [WIDTH-1:0]  D,
    input  logic [CHAINS-1:0] SI,
    output logic [WIDTH-1:0]  Q,
    output logic [WIDTH-1:0]  QN,
    output logic [CHAINS-1:0] SO,
    output logic [CW-1:0]     SCNT,
    output logic              LOADED
`ifdef SCAN_MISR_EN
    ,
    output logic [MISR_W-1:0] SIG
`endif
);

    localparam logic [CW-1:0] LEN_C  = CW'(LEN);
    localparam logic [CW-1:0] LEN_M1 = CW'(LEN - 1);

    logic [WIDTH-1:0]  r_q;
    logic [WIDTH-1:0]  w_shift;
    logic [CHAINS-1:0] w_so;
    logic [CW-1:0]     r_scnt;
    scnt_state_e       r_state;
    scnt_state_e       w_state_nxt;
    logic              w_cnt_inc;

    // SI enters each chain at its MSB; data moves toward the chain LSB.
    always_comb begin
        w_shift = r_q;
        for (int c = 0; c < CHAINS; c++) begin
            for (int i = 0; i < LEN - 1; i++) begin
                w_shift[c*LEN+i] = r_q[c*LEN+i+1];
            end
            w_shift[c*LEN+LEN-1] = SI[c];
        end
    end

    always_comb begin
        w_so = '0;
        for (int c = 0; c < CHAINS; c++) begin
            w_so[c] = r_q[c*LEN];
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            r_q <= RST_VAL;
        end else if (SE) begin
            r_q <= w_shift;
        end else if (E) begin
            r_q <= D;
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            r_state <= SC_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = SC_IDLE;
        if (SE) begin
            if (r_state == SC_FULL || r_scnt == LEN_M1) begin
                w_state_nxt = SC_FULL;
            end else begin
                w_state_nxt = SC_SHIFT;
            end
        end
    end

    // Counting stops once the chain is full; shifting itself carries on.
    always_comb begin
        w_cnt_inc = SE && (r_state != SC_FULL);
    end

    always_ff @(posedge CK) begin
        if (RST || !SE) begin
            r_scnt <= '0;
        end else if (w_cnt_inc) begin
            r_scnt <= r_scnt + 1'b1;
        end
    end

    assign Q      = r_q;
    assign QN     = ~r_q;
    assign SO     = w_so;
    assign SCNT   = r_scnt;
    assign LOADED = (r_scnt == LEN_C);

`ifdef SCAN_MISR_EN
    scan_misr #(
        .CHAINS (CHAINS)
    ) u_misr (
        .CK  (CK),
        .RST (RST),
        .EN  (SE),
        .DIN (w_so),
        .SIG (SIG)
    );
`endif

endmodule

// File: tb/tb_scan_reg_bank.sv
// Self-checking bench for scan_reg_bank (WIDTH=8, CHAINS=2) against a behavioural model.
module tb_scan_reg_bank;

    localparam int WIDTH  = 8;
    localparam int CHAINS = 2;
    localparam int LEN    = WIDTH / CHAINS;
    localparam int CW     = $clog2(LEN + 1);

    logic              ck = 1'b0;
    logic              rst, e, se;
    logic [WIDTH-1:0]  d, q, qn;
    logic [CHAINS-1:0] si, so;
    logic [CW-1:0]     scnt;
    logic              loaded;

    int errors = 0;
    int checks = 0;

    int m_q, m_cnt, m_sig;

    always #5 ck = ~ck;

`ifdef SCAN_MISR_EN
    logic [15:0] sig;
    logic        rst2, e2, se2;
    logic [15:0] d2, q2, qn2, sig2;
    logic [3:0]  si2, so2;
    logic [2:0]  scnt2;
    logic        loaded2;

    scan_reg_bank #(.WIDTH(16), .CHAINS(4), .RST_VAL(16'h0000)) dut2 (
        .CK(ck), .RST(rst2), .E(e2), .SE(se2), .D(d2), .SI(si2),
        .Q(q2), .QN(qn2), .SO(so2), .SCNT(scnt2), .LOADED(loaded2), .SIG(sig2)
    );
`endif

    scan_reg_bank #(.WIDTH(WIDTH), .CHAINS(CHAINS), .RST_VAL(8'h00)) dut (
        .CK(ck), .RST(rst), .E(e), .SE(se), .D(d), .SI(si),
        .Q(q), .QN(qn), .SO(so), .SCNT(scnt), .LOADED(loaded)
`ifdef SCAN_MISR_EN
        , .SIG(sig)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_so(input int qv);
        int r = 0;
        for (int c = 0; c < CHAINS; c++) r |= ((qv >> (c * LEN)) & 1) << c;
        return r;
    endfunction

    function automatic int misr_step(input int s, input int din);
        int n = (s << 1) & 16'hFFFF;
        if ((s >> 15) & 1) n = n ^ 16'h100B;
        return n ^ din;
    endfunction

    // Reference update for one rising edge, using the inputs sampled at that edge.
    task automatic model_edge();
        int nq, ch;
        if (rst) begin
            m_q = 0; m_cnt = 0; m_sig = 0;
        end else if (se) begin
            m_sig = misr_step(m_sig, model_so(m_q));
            nq = 0;
            for (int c = 0; c < CHAINS; c++) begin
                ch = (m_q >> (c * LEN)) & ((1 << LEN) - 1);
                ch = (ch >> 1) | (int'(si[c]) << (LEN - 1));
                nq |= ch << (c * LEN);
            end
            m_q = nq;
            m_cnt = (m_cnt + 1 > LEN) ? LEN : m_cnt + 1;
        end else begin
            if (e) m_q = int'(d);
            m_cnt = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".Q"}, 32'(q), 32'(m_q));
        check({tag, ".QN"}, 32'(qn), 32'((~m_q) & 8'hFF));
        check({tag, ".SO"}, 32'(so), 32'(model_so(m_q)));
        check({tag, ".SCNT"}, 32'(scnt), 32'(m_cnt));
        check({tag, ".LOADED"}, 32'(loaded), 32'(m_cnt == LEN));
`ifdef SCAN_MISR_EN
        check({tag, ".SIG"}, 32'(sig), 32'(m_sig));
`endif
    endtask

    task automatic tick(input string tag);
        @(posedge ck);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [1:0] exp_so [4];
        exp_so[0] = 2'b01; exp_so[1] = 2'b10; exp_so[2] = 2'b01; exp_so[3] = 2'b10;
        m_q = 0; m_cnt = 0; m_sig = 0;
        rst = 1'b1; e = 1'b0; se = 1'b0; d = '0; si = '0;
`ifdef SCAN_MISR_EN
        rst2 = 1'b1; e2 = 1'b0; se2 = 1'b0; d2 = '0; si2 = '0;
`endif
        #1;

        // Reset
        tick("reset");
        check("reset.Q_const", 32'(q), 32'h00);
        check("reset.QN_const", 32'(qn), 32'hFF);
        check("reset.SO_const", 32'(so), 32'h0);
        rst = 1'b0;

        // Capture then hold
        e = 1'b1; d = 8'hA5;
        tick("capture");
        check("capture.Q_const", 32'(q), 32'hA5);
        check("capture.QN_const", 32'(qn), 32'h5A);
        e = 1'b0; d = 8'h00;
        tick("hold");
        check("hold.Q_const", 32'(q), 32'hA5);

        // Shift 5 cycles with SI=11
        se = 1'b1; si = 2'b11;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) check("shift.SO_pre", 32'(so), 32'(exp_so[k]));
            tick("shift");
            check("shift.SCNT_const", 32'(scnt), 32'((k + 1 > 4) ? 4 : k + 1));
            check("shift.LOADED_const", 32'(loaded), 32'(k >= 3));
        end
        check("shift.Q_full", 32'(q), 32'hFF);

        // Priority: SE over E, RST over SE
        se = 1'b0; e = 1'b1; d = 8'h3C;
        tick("prio_load");
        se = 1'b1; e = 1'b1; d = 8'h00; si = 2'b00;
        tick("prio_se_e");
        check("prio_se_e.Q_const", 32'(q), 32'h16);
        rst = 1'b1;
        tick("prio_rst_se");
        check("prio_rst_se.SCNT_const", 32'(scnt), 32'h0);
        rst = 1'b0; e = 1'b0;

        // Reset mid-shift, then resume
        si = 2'b10;
        tick("mid_shift1");
        tick("mid_shift2");
        rst = 1'b1;
        tick("mid_rst");
        check("mid_rst.Q_const", 32'(q), 32'h00);
        rst = 1'b0;
        tick("mid_resume");
        check("mid_resume.SCNT_const", 32'(scnt), 32'h1);

        // One-cycle SE drop clears the count
        se = 1'b0;
        tick("se_drop");
        se = 1'b1;
        tick("se_back");
        check("se_back.SCNT_const", 32'(scnt), 32'h1);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            rst = ($urandom_range(0, 24) == 0);
            se  = ($urandom_range(0, 3) != 0);
            e   = $urandom_range(0, 1) != 0;
            d   = 8'($urandom);
            si  = 2'($urandom);
            tick("rand");
        end
        rst = 1'b0; se = 1'b0; e = 1'b0;

`ifdef SCAN_MISR_EN
        // MISR signature on a 16-bit, 4-chain bank
        rst2 = 1'b1;
        tick("misr_rst");
        check("misr_rst.SIG", 32'(sig2), 32'h0);
        rst2 = 1'b0; e2 = 1'b1; d2 = 16'h0001;
        tick("misr_load");
        check("misr_load.SO", 32'(so2), 32'h1);
        e2 = 1'b0; se2 = 1'b1; si2 = 4'h0;
        tick("misr_s1");
        check("misr_s1.SIG", 32'(sig2), 32'h0001);
        check("misr_s1.SO", 32'(so2), 32'h0);
        tick("misr_s2");
        check("misr_s2.SIG", 32'(sig2), 32'h0002);
        for (int k = 0; k < 14; k++) tick("misr_run");
        check("misr_msb.SIG", 32'(sig2), 32'h8000);
        tick("misr_wrap");
        check("misr_wrap.SIG", 32'(sig2), 32'h100B);
        se2 = 1'b0;
        tick("misr_hold");
        check("misr_hold.SIG", 32'(sig2), 32'h100B);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
